axi_slave_wr_ctrl: RTL

//  AXI3 write-path slave that sits directly downstream of the AXI master interface.

---
 rtl/axi_slave_wr_ctrl_if.sv | 44 ++++
 rtl/axi_slave_wr_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/axi_slave_wr_ctrl_if.sv
// AXI3 write-channel bundle (AW, W, B) between an AXI master and axi_slave_wr_ctrl.
// All three channels transfer on a rising clock edge where valid and ready are both high; valid never waits on ready.
interface axi_slave_wr_ctrl_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128
);
    logic [3:0]              awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [3:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [3:0]              wid;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [3:0]              bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_slave_wr_ctrl.sv
// AXI3 write slave: one burst at a time, each beat becomes a registered memory write, one B per burst.
// Optional AXI_WR_PROTOCOL_CHK_EN adds wid/wlast protocol checking that turns the response into SLVERR.
module axi_slave_wr_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128
) (
    input  logic                    aclk,
    input  logic                    areset,
    axi_slave_wr_ctrl_if.slave      bus,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic [1:0]              dbg_state
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_WIDTH));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;

    logic [3:0]            id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [3:0]            beat_q;
    logic                  err_q;

    logic aw_hs, w_hs, b_hs, last_beat, aw_err, proto_next;
    logic [ADDR_WIDTH-1:0] step, incr_addr, wrap_mask, wrap_addr, addr_next;
    logic [2:0]            wrap_shift;

    assign aw_hs     = bus.awvalid & bus.awready;
    assign w_hs      = bus.wvalid & bus.wready;
    assign b_hs      = bus.bvalid & bus.bready;
    assign last_beat = (beat_q == len_q);
    assign dbg_state = state;

    // A WRAP burst is only legal for 2, 4, 8 or 16 beats.
    always_comb begin
        aw_err = 1'b0;
        if (bus.awburst == 2'b11)
            aw_err = 1'b1;
        if (bus.awsize > MAX_SIZE)
            aw_err = 1'b1;
        if (bus.awburst == 2'b10 && bus.awlen != 4'd1 && bus.awlen != 4'd3 &&
            bus.awlen != 4'd7 && bus.awlen != 4'd15)
            aw_err = 1'b1;
    end

    // Legal wrap lengths are powers of two, so the wrap window is a shifted beat size.
    always_comb begin
        wrap_shift = 3'd4;
        case (len_q)
            4'd1:    wrap_shift = 3'd1;
            4'd3:    wrap_shift = 3'd2;
            4'd7:    wrap_shift = 3'd3;
            default: wrap_shift = 3'd4;
        endcase
        step      = ADDR_WIDTH'(1) << size_q;
        incr_addr = addr_q + step;
        wrap_mask = (step << wrap_shift) - ADDR_WIDTH'(1);
        wrap_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
        addr_next = addr_q;
        case (burst_q)
            2'b01:   addr_next = incr_addr;
            2'b10:   addr_next = wrap_addr;
            default: addr_next = addr_q;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (aw_hs) state_next = DATA;
            DATA:    if (w_hs && last_beat) state_next = RESP;
            RESP:    if (b_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef AXI_WR_PROTOCOL_CHK_EN
    logic proto_q;

    assign proto_next = proto_q | (bus.wid != id_q) | (bus.wlast != last_beat);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            proto_q <= 1'b0;
        else if (aw_hs)
            proto_q <= 1'b0;
        else if (w_hs)
            proto_q <= proto_next;
    end
`else
    logic unused_proto;
    assign unused_proto = ^{bus.wid, bus.wlast};
    assign proto_next   = 1'b0;
`endif

    // Handshake outputs are registered decodes of the next state so they read 0 while in reset.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b0;
            bus.bid     <= '0;
            bus.bresp   <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            beat_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_next;
            bus.awready <= (state_next == IDLE);
            bus.wready  <= (state_next == DATA);
            bus.bvalid  <= (state_next == RESP);
            mem_we      <= 1'b0;
            if (aw_hs) begin
                id_q    <= bus.awid;
                addr_q  <= bus.awaddr;
                len_q   <= bus.awlen;
                size_q  <= bus.awsize;
                burst_q <= bus.awburst;
                beat_q  <= '0;
                err_q   <= aw_err;
            end
            if (w_hs) begin
                beat_q    <= beat_q + 4'd1;
                addr_q    <= addr_next;
                mem_we    <= ~err_q;
                mem_addr  <= addr_q;
                mem_wdata <= bus.wdata;
                mem_wstrb <= bus.wstrb;
                if (last_beat) begin
                    bus.bid   <= id_q;
                    bus.bresp <= (err_q | proto_next) ? 2'b10 : 2'b00;
                end
            end
        end
    end
endmodule
